// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; UART_RX_PARITY_EN adds a parity bit.
// Two-flop synchroniser, mid-bit sampling, false-start rejection.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BRK
  } state_e;

  state_e      state_q;
  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    byte_q;
  logic          valid_q;
  logic          busy_q;
  logic          ferr_q;

`ifdef UART_RX_PARITY_EN
  logic par_ok_q;
  logic perr_q;
  assign rx_parity_err = perr_q;
`else
  localparam logic par_ok_q = 1'b1;
  logic unused_par;
  assign unused_par = PARITY_ODD;
  assign rx_parity_err = 1'b0;
`endif

  assign rx_byte      = byte_q;
  assign rx_valid     = valid_q;
  assign rx_busy      = busy_q;
  assign rx_frame_err = ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q <= 1'b1;
      perr_q   <= 1'b0;
`endif
    end else begin
      meta_q  <= rx_in;
      sync_q  <= meta_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!sync_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (!sync_q) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end else begin
              // line went back high: glitch, not a start bit
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync_q, shift_q[7:1]};
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PAR;
`else
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          if (cnt_q == LAST) begin
            cnt_q    <= '0;
            par_ok_q <= (sync_q == (^shift_q ^ PARITY_ODD));
            state_q  <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (sync_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (par_ok_q) begin
                byte_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
`ifdef UART_RX_PARITY_EN
                perr_q  <= 1'b1;
`endif
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BRK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_BRK: begin
          cnt_q <= '0;
          if (sync_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16-clk bit instance plus a 217-clk instance.
// Parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int CPB_B = 217;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] a_byte, b_byte;
  logic       a_valid, a_busy, a_ferr, a_perr;
  logic       b_valid, b_busy, b_ferr, b_perr;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_a),
    .rx_byte(a_byte), .rx_valid(a_valid), .rx_busy(a_busy),
    .rx_frame_err(a_ferr), .rx_parity_err(a_perr)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B), .PARITY_ODD(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_b),
    .rx_byte(b_byte), .rx_valid(b_valid), .rx_busy(b_busy),
    .rx_frame_err(b_ferr), .rx_parity_err(b_perr)
  );

  int checks = 0;
  int failures = 0;
  int a_vcnt = 0, a_fcnt = 0, a_pcnt = 0;
  int b_vcnt = 0, ovl = 0;
  int cyc = 0, lat_t = 0, t_fall = 0;
  int v0, f0, p0, n0, hits, d;
  logic [7:0] tmp;
  logic [7:0] a_log[$];

  always @(posedge clk) begin
    if (a_valid) begin
      a_vcnt++;
      a_log.push_back(a_byte);
      lat_t = cyc;
    end
    if (a_ferr) a_fcnt++;
    if (a_perr) a_pcnt++;
    if (a_valid && a_ferr) ovl++;
    if (b_valid) b_vcnt++;
    if (b_valid && b_ferr) ovl++;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input int n);
    @(negedge clk);
    if (sel == 0) rx_a = v;
    else rx_b = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send(input int sel, input logic [7:0] dat,
                      input logic stop, input logic pflip);
    int n;
    n = (sel == 0) ? CPB : CPB_B;
    @(negedge clk);
    if (sel == 0) rx_a = 1'b0;
    else rx_b = 1'b0;
    t_fall = cyc;
    repeat (n - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive(sel, dat[i], n);
    if (PB != 0) drive(sel, ^dat ^ pflip, n);
    drive(sel, stop, n);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_byte", a_byte, 8'h00);
    chk("rst_valid", a_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ferr", a_ferr, 0);
    chk("rst_perr", a_perr, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: plain frame and latency
    v0 = a_vcnt;
    send(0, 8'hA5, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("t1_vcnt", a_vcnt - v0, 1);
    chk("t1_byte", a_byte, 8'hA5);
    chk("t1_busy", a_busy, 0);
    chk("t1_ferr", a_fcnt, 0);
    d = lat_t - t_fall;
    chk("t1_lat", (d >= 153 + 16 * PB) && (d <= 157 + 16 * PB), 1);

    // 2: short low pulse is rejected
    v0 = a_vcnt;
    @(negedge clk);
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("t2_busy_hi", a_busy, 1);
    rx_a = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("t2_busy_lo", a_busy, 0);
    chk("t2_vcnt", a_vcnt - v0, 0);
    chk("t2_ferr", a_fcnt, 0);

    // 3: bad stop bit, held break, then recovery
    v0 = a_vcnt;
    f0 = a_fcnt;
    send(0, 8'h3C, 1'b0, 1'b0);
    chk("t3_ferr", a_fcnt - f0, 1);
    chk("t3_byte_kept", a_byte, 8'hA5);
    repeat (100) @(negedge clk);
    chk("t3_brk_busy", a_busy, 1);
    chk("t3_brk_vcnt", a_vcnt - v0, 0);
    chk("t3_brk_ferr", a_fcnt - f0, 1);
    rx_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("t3_idle", a_busy, 0);
    send(0, 8'h11, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("t3_vcnt", a_vcnt - v0, 1);
    chk("t3_byte", a_byte, 8'h11);

    // 4: back-to-back frames, then the 217-clk instance
    v0 = a_vcnt;
    n0 = a_log.size();
    send(0, 8'h00, 1'b1, 1'b0);
    send(0, 8'hFF, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("t4_vcnt", a_vcnt - v0, 2);
    chk("t4_first", a_log.size() > n0 ? a_log[n0] : 8'hEE, 8'h00);
    chk("t4_second", a_log.size() > n0 + 1 ? a_log[n0 + 1] : 8'hEE, 8'hFF);
    send(1, 8'h96, 1'b1, 1'b0);
    repeat (CPB_B) @(negedge clk);
    chk("t4_b_vcnt", b_vcnt, 1);
    chk("t4_b_byte", b_byte, 8'h96);
    chk("t4_b_busy", b_busy, 0);

    // 5: reset in the middle of a frame
    v0 = a_vcnt;
    tmp = 8'h5A;
    drive(0, 1'b0, CPB);
    for (int i = 0; i < 3; i++) drive(0, tmp[i], CPB);
    rst_n = 1'b0;
    rx_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_rst_byte", a_byte, 8'h00);
    chk("t5_rst_busy", a_busy, 0);
    chk("t5_rst_valid", a_valid, 0);
    chk("t5_rst_ferr", a_ferr, 0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send(0, 8'hC3, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("t5_vcnt", a_vcnt - v0, 1);
    chk("t5_byte", a_byte, 8'hC3);
    hits = 0;
    foreach (a_log[i]) if (a_log[i] == 8'h5A) hits++;
    chk("t5_no_5a", hits, 0);

    // 6: parity
    v0 = a_vcnt;
    p0 = a_pcnt;
`ifdef UART_RX_PARITY_EN
    send(0, 8'h07, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("t6_good_vcnt", a_vcnt - v0, 1);
    chk("t6_good_byte", a_byte, 8'h07);
    chk("t6_good_perr", a_pcnt - p0, 0);
    send(0, 8'h07, 1'b1, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("t6_bad_perr", a_pcnt - p0, 1);
    chk("t6_bad_vcnt", a_vcnt - v0, 1);
    chk("t6_bad_byte", a_byte, 8'h07);
`else
    chk("t6_no_perr", a_pcnt - p0, 0);
    chk("t6_perr_lvl", a_perr, 0);
`endif

    chk("overlap", ovl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
